// File: rtl/ifetch_unit.sv
// Instruction-fetch reader: owns the fetch PC, issues one word request at a time
// to instruction memory and buffers returned instructions with their PCs for decode.
`timescale 1ns/1ps
module ifetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clock,
    input  logic        NReset,
    input  logic        Redirect,
    input  logic [31:0] RedirectAddr,
    output logic        MemReq,
    output logic [31:0] MemAddr,
    input  logic        MemAck,
    input  logic        MemRValid,
    input  logic [31:0] MemRData,
    output logic        InstValid,
    output logic [31:0] Inst,
    output logic [31:0] InstPC,
    input  logic        InstReady,
    output logic [31:0] FetchPC
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] FULL_C = (PW+1)'(DEPTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DROP = 2'd2;

    logic [1:0]    state_r;
    logic [1:0]    state_nxt_s;
    logic [31:0]   fetch_pc_r;
    logic [31:0]   req_pc_r;
    logic [PW:0]   count_r;
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [31:0]   inst_mem_r [DEPTH];
    logic [31:0]   pc_mem_r   [DEPTH];
    logic          req_s;
    logic          push_s;
    logic          pop_s;
    logic          valid_s;
    logic [1:0]    unused_addr_s;

    assign unused_addr_s = RedirectAddr[1:0];

    // Request, push and pop qualification; the request is gated by reset so it is low during reset.
    always_comb begin
        valid_s = (count_r != {(PW+1){1'b0}});
        if (NReset && (state_r == IDLE) && !Redirect && (count_r != FULL_C)) begin
            req_s = 1'b1;
        end else begin
            req_s = 1'b0;
        end
        push_s = (state_r == WAIT) && MemRValid && !Redirect;
        pop_s  = valid_s && InstReady && !Redirect;
    end

    // Next-state logic of the single-outstanding-request controller.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_s && MemAck) begin
                    state_nxt_s = WAIT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT: begin
                if (MemRValid) begin
                    state_nxt_s = IDLE;
                end else if (Redirect) begin
                    state_nxt_s = DROP;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            DROP: begin
                if (MemRValid) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DROP;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Controller state, fetch address and the PC of the outstanding request.
    always_ff @(posedge Clock or negedge NReset) begin
        if (!NReset) begin
            state_r    <= IDLE;
            fetch_pc_r <= RESET_PC;
            req_pc_r   <= 32'h0000_0000;
        end else begin
            state_r <= state_nxt_s;
            if (Redirect) begin
                fetch_pc_r <= {RedirectAddr[31:2], 2'b00};
            end else if (req_s && MemAck) begin
                fetch_pc_r <= fetch_pc_r + 32'd4;
            end
            if (req_s && MemAck) begin
                req_pc_r <= fetch_pc_r;
            end
        end
    end

    // FIFO occupancy and pointers; a redirect empties the buffer and drops any pop.
    always_ff @(posedge Clock or negedge NReset) begin
        if (!NReset) begin
            count_r  <= {(PW+1){1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
        end else if (Redirect) begin
            count_r  <= {(PW+1){1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (PW+1)'(1);
                2'b01:   count_r <= count_r - (PW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // FIFO storage; contents are only visible when the entry is valid.
    always_ff @(posedge Clock) begin
        if (push_s) begin
            inst_mem_r[wr_ptr_r] <= MemRData;
            pc_mem_r[wr_ptr_r]   <= req_pc_r;
        end
    end

    assign MemReq    = req_s;
    assign MemAddr   = fetch_pc_r;
    assign FetchPC   = fetch_pc_r;
    assign InstValid = valid_s;
    assign Inst      = valid_s ? inst_mem_r[rd_ptr_r] : 32'h0000_0000;
    assign InstPC    = valid_s ? pc_mem_r[rd_ptr_r]   : 32'h0000_0000;

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed vector table, hand-written corner
// sequences and a randomized run against an in-order instruction-stream model.
`timescale 1ns/1ps
module tb_ifetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        Clock;
    logic        NReset;
    logic        Redirect;
    logic [31:0] RedirectAddr;
    logic        MemReq;
    logic [31:0] MemAddr;
    logic        MemAck;
    logic        MemRValid;
    logic [31:0] MemRData;
    logic        InstValid;
    logic [31:0] Inst;
    logic [31:0] InstPC;
    logic        InstReady;
    logic [31:0] FetchPC;

    ifetch_unit #(.DEPTH(4), .RESET_PC(RESET_PC)) dut (
        .Clock(Clock), .NReset(NReset),
        .Redirect(Redirect), .RedirectAddr(RedirectAddr),
        .MemReq(MemReq), .MemAddr(MemAddr), .MemAck(MemAck),
        .MemRValid(MemRValid), .MemRData(MemRData),
        .InstValid(InstValid), .Inst(Inst), .InstPC(InstPC),
        .InstReady(InstReady), .FetchPC(FetchPC)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic        red;
        logic [31:0] raddr;
        logic        ack;
        logic        rv;
        logic [31:0] rdata;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_fpc;
    } vec_t;

    int errors = 0;
    int checks = 0;

    // memory model and instruction-stream reference
    bit          mem_pend;
    int          mem_wait;
    logic [31:0] mem_addr;
    int          lat_min = 1;
    int          lat_max = 1;
    bit          ack_rand = 1'b0;
    logic        cap_req, cap_ack, cap_rv;
    logic [31:0] cap_addr;
    logic [31:0] exp_pc;
    int          pops = 0;
    logic [31:0] req_q [$];

    function automatic logic [31:0] dat(input logic [31:0] pc);
        return {pc[15:0], pc[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    function automatic vec_t mk(input logic red, input logic [31:0] raddr, input logic ack,
                                input logic rv, input logic [31:0] rdata, input logic rdy,
                                input logic e_req, input logic [31:0] e_addr, input logic e_valid,
                                input logic [31:0] e_pc, input logic [31:0] e_fpc);
        vec_t v;
        v.red = red; v.raddr = raddr; v.ack = ack; v.rv = rv; v.rdata = rdata; v.rdy = rdy;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc; v.e_fpc = e_fpc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge Clock);
        @(negedge Clock);
        NReset = 1'b0; Redirect = 1'b0; RedirectAddr = 32'h0; MemAck = 1'b0;
        MemRValid = 1'b0; MemRData = 32'h0; InstReady = 1'b0;
        mem_pend = 1'b0; mem_wait = 0; cap_req = 1'b0; cap_ack = 1'b0; cap_rv = 1'b0;
        exp_pc = RESET_PC;
        req_q.delete();
        #1;
        chk("rst_memreq", {31'h0, MemReq}, 32'h0);
        chk("rst_instvalid", {31'h0, InstValid}, 32'h0);
        chk("rst_inst", Inst, 32'h0);
        chk("rst_instpc", InstPC, 32'h0);
        chk("rst_fetchpc", FetchPC, RESET_PC);
        chk("rst_memaddr", MemAddr, RESET_PC);
        #2 NReset = 1'b1;
    endtask

    // One cycle with memory fully driven by the vector; outputs compared mid-cycle.
    task automatic row_apply(input vec_t v, input string nm);
        @(posedge Clock);
        @(negedge Clock);
        Redirect = v.red; RedirectAddr = v.raddr; MemAck = v.ack;
        MemRValid = v.rv; MemRData = v.rdata; InstReady = v.rdy;
        #1;
        chk({nm, "_memreq"}, {31'h0, MemReq}, {31'h0, v.e_req});
        chk({nm, "_memaddr"}, MemAddr, v.e_addr);
        chk({nm, "_instvalid"}, {31'h0, InstValid}, {31'h0, v.e_valid});
        chk({nm, "_fetchpc"}, FetchPC, v.e_fpc);
        if (v.e_valid) begin
            chk({nm, "_instpc"}, InstPC, v.e_pc);
            chk({nm, "_inst"}, Inst, dat(v.e_pc));
        end
        cap_req = 1'b0; cap_ack = 1'b0; cap_rv = 1'b0; mem_pend = 1'b0;
    endtask

    // One cycle with the memory model answering requests and the stream model checking pops.
    task automatic step(input logic red, input logic [31:0] raddr, input logic rdy);
        @(posedge Clock);
        if (cap_rv) begin
            mem_pend = 1'b0;
        end else if (mem_pend && mem_wait > 0) begin
            mem_wait--;
        end
        if (cap_req && cap_ack) begin
            mem_pend = 1'b1;
            mem_addr = cap_addr;
            mem_wait = int'($urandom_range(lat_max, lat_min)) - 1;
            req_q.push_back(cap_addr);
        end
        @(negedge Clock);
        Redirect = red; RedirectAddr = raddr; InstReady = rdy;
        MemRValid = mem_pend && (mem_wait == 0);
        MemRData = MemRValid ? dat(mem_addr) : $urandom;
        MemAck = ack_rand ? ($urandom_range(2, 0) != 0) : 1'b1;
        #1;
        if (MemReq) chk("single_outstanding", {31'h0, mem_pend}, 32'h0);
        if (cap_req && !cap_ack && !red) begin
            chk("req_hold", {31'h0, MemReq}, 32'h1);
            chk("addr_hold", MemAddr, cap_addr);
        end
        if (red) begin
            exp_pc = {raddr[31:2], 2'b00};
        end else if (InstValid && rdy) begin
            chk("pop_pc", InstPC, exp_pc);
            chk("pop_inst", Inst, dat(exp_pc));
            exp_pc = exp_pc + 32'd4;
            pops++;
        end
        cap_req = MemReq; cap_ack = MemAck; cap_rv = MemRValid; cap_addr = MemAddr;
    endtask

    vec_t vecs [17];
    vec_t rv_a, rv_b;
    int   p0;

    initial begin
        NReset = 1'b0; Redirect = 1'b0; RedirectAddr = 32'h0; MemAck = 1'b0;
        MemRValid = 1'b0; MemRData = 32'h0; InstReady = 1'b0;

        // sequential fetch with 1-cycle memory, then redirect in WAIT with a late response
        vecs[0]  = mk(1'b0, 32'h0,    1'b1, 1'b0, 32'h0,          1'b1, 1'b1, 32'h0,    1'b0, 32'h0,    32'h0);
        vecs[1]  = mk(1'b0, 32'h0,    1'b0, 1'b1, dat(32'h0),     1'b1, 1'b0, 32'h4,    1'b0, 32'h0,    32'h4);
        vecs[2]  = mk(1'b0, 32'h0,    1'b1, 1'b0, 32'h0,          1'b1, 1'b1, 32'h4,    1'b1, 32'h0,    32'h4);
        vecs[3]  = mk(1'b0, 32'h0,    1'b0, 1'b1, dat(32'h4),     1'b1, 1'b0, 32'h8,    1'b0, 32'h0,    32'h8);
        vecs[4]  = mk(1'b0, 32'h0,    1'b1, 1'b0, 32'h0,          1'b1, 1'b1, 32'h8,    1'b1, 32'h4,    32'h8);
        vecs[5]  = mk(1'b0, 32'h0,    1'b0, 1'b1, dat(32'h8),     1'b1, 1'b0, 32'hC,    1'b0, 32'h0,    32'hC);
        vecs[6]  = mk(1'b0, 32'h0,    1'b1, 1'b0, 32'h0,          1'b1, 1'b1, 32'hC,    1'b1, 32'h8,    32'hC);
        vecs[7]  = mk(1'b0, 32'h0,    1'b0, 1'b1, dat(32'hC),     1'b1, 1'b0, 32'h10,   1'b0, 32'h0,    32'h10);
        vecs[8]  = mk(1'b0, 32'h0,    1'b0, 1'b0, 32'h0,          1'b1, 1'b1, 32'h10,   1'b1, 32'hC,    32'h10);
        vecs[9]  = mk(1'b0, 32'h0,    1'b1, 1'b0, 32'h0,          1'b1, 1'b1, 32'h10,   1'b0, 32'h0,    32'h10);
        vecs[10] = mk(1'b1, 32'h1003, 1'b0, 1'b0, 32'h0,          1'b1, 1'b0, 32'h14,   1'b0, 32'h0,    32'h14);
        vecs[11] = mk(1'b0, 32'h0,    1'b0, 1'b0, 32'h0,          1'b1, 1'b0, 32'h1000, 1'b0, 32'h0,    32'h1000);
        vecs[12] = mk(1'b0, 32'h0,    1'b0, 1'b0, 32'h0,          1'b1, 1'b0, 32'h1000, 1'b0, 32'h0,    32'h1000);
        vecs[13] = mk(1'b0, 32'h0,    1'b0, 1'b1, dat(32'h10),    1'b1, 1'b0, 32'h1000, 1'b0, 32'h0,    32'h1000);
        vecs[14] = mk(1'b0, 32'h0,    1'b1, 1'b0, 32'h0,          1'b1, 1'b1, 32'h1000, 1'b0, 32'h0,    32'h1000);
        vecs[15] = mk(1'b0, 32'h0,    1'b0, 1'b1, dat(32'h1000),  1'b1, 1'b0, 32'h1004, 1'b0, 32'h0,    32'h1004);
        vecs[16] = mk(1'b0, 32'h0,    1'b0, 1'b0, 32'h0,          1'b1, 1'b1, 32'h1004, 1'b1, 32'h1000, 32'h1004);

        do_reset();
        for (int i = 0; i < 17; i++) row_apply(vecs[i], $sformatf("vec%0d", i));

        // fill with decode stalled: exactly 4 accepted, then drain and resume at 0x10
        do_reset();
        for (int i = 0; i < 12; i++) step(1'b0, 32'h0, 1'b0);
        chk("fill_memreq_full", {31'h0, MemReq}, 32'h0);
        chk("fill_instvalid", {31'h0, InstValid}, 32'h1);
        chk("fill_head_pc", InstPC, 32'h0);
        chk("fill_fetchpc", FetchPC, 32'h10);
        chk("fill_accepted", req_q.size(), 32'd4);
        step(1'b0, 32'h0, 1'b1);
        chk("fill_still_full", {31'h0, MemReq}, 32'h0);
        step(1'b0, 32'h0, 1'b1);
        chk("resume_memreq", {31'h0, MemReq}, 32'h1);
        chk("resume_addr", MemAddr, 32'h10);
        for (int i = 0; i < 12; i++) step(1'b0, 32'h0, 1'b1);
        chk("drain_pops", (pops >= 5) ? 32'h1 : 32'h0, 32'h1);

        // redirect coincident with read data while two entries are buffered
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b0);
        step(1'b1, 32'h2000, 1'b1);
        chk("rdv_pre_valid", {31'h0, InstValid}, 32'h1);
        chk("rdv_pre_pc", InstPC, 32'h0);
        step(1'b0, 32'h0, 1'b1);
        chk("rdv_flushed", {31'h0, InstValid}, 32'h0);
        chk("rdv_fetchpc", FetchPC, 32'h2000);
        chk("rdv_memreq", {31'h0, MemReq}, 32'h1);
        chk("rdv_memaddr", MemAddr, 32'h2000);
        for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1);

        // address wrap at the top of memory
        do_reset();
        p0 = pops;
        step(1'b1, 32'hFFFF_FFFC, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1);
        if (req_q.size() >= 2) begin
            chk("wrap_req0", req_q[0], 32'hFFFF_FFFC);
            chk("wrap_req1", req_q[1], 32'h0000_0000);
        end else begin
            chk("wrap_req_count", req_q.size(), 32'd2);
        end
        chk("wrap_pops", (pops - p0 >= 2) ? 32'h1 : 32'h0, 32'h1);

        // reset while a request is outstanding; the late response must be ignored
        do_reset();
        lat_min = 3; lat_max = 3;
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        do_reset();
        rv_a = mk(1'b0, 32'h0, 1'b0, 1'b1, dat(32'h0), 1'b1, 1'b1, RESET_PC, 1'b0, 32'h0, RESET_PC);
        rv_b = mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0,      1'b1, 1'b1, RESET_PC, 1'b0, 32'h0, RESET_PC);
        row_apply(rv_a, "stale_rv");
        row_apply(rv_b, "stale_after");

        // randomized traffic: variable latency, random acks, stalls and redirects
        do_reset();
        lat_min = 1; lat_max = 4; ack_rand = 1'b1;
        p0 = pops;
        for (int c = 0; c < 3000; c++) begin
            logic        r;
            logic [31:0] a;
            logic        rdy;
            r   = ($urandom_range(24, 0) == 0);
            a   = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            rdy = ((c % 300) < 60) ? 1'b0 : 1'(($urandom_range(1, 0)));
            step(r, a, rdy);
        end
        chk("random_progress", (pops - p0 > 100) ? 32'h1 : 32'h0, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
